// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator-machine memory arbiter.
// Holds the FSM state enum, width/region defaults and requester IDs.
package acc_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int L_INS_DEF  = 401;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_IND,
    S_RD2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_ID = 1'b1;

endpackage

// File: rtl/acc_rr_pick.sv
// Two-requester round-robin pick (IF vs ID) with an override that
// blocks both grants. Ports: clk_i, rst_i, en_i, ovr_i, req_*_i, gnt_*_o.
module acc_rr_pick
  import acc_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic ovr_i,
  input  logic req_if_i,
  input  logic req_id_i,
  output logic gnt_if_o,
  output logic gnt_id_o
);

  // fav_q names the requester that wins a tie
  logic fav_q;
  logic fav_d;

  always_comb begin
    gnt_if_o = 1'b0;
    gnt_id_o = 1'b0;
    if (en_i && !ovr_i) begin
      if (req_id_i && (!req_if_i || fav_q == REQ_ID))
        gnt_id_o = 1'b1;
      else if (req_if_i)
        gnt_if_o = 1'b1;
    end
    fav_d = fav_q;
    if (gnt_id_o)
      fav_d = REQ_IF;
    else if (gnt_if_o)
      fav_d = REQ_ID;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      fav_q <= REQ_ID;
    else
      fav_q <= fav_d;
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Single-port memory arbiter: loader writes, IF reads, ID direct/indirect
// reads with data-region bound check. Ports: clk1, rst, if_*, id_*, ld_*, mem_*.
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int L_INS  = L_INS_DEF
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              id_req,
  input  logic              id_ind,
  input  logic [ADDR_W-1:0] id_addr,
  output logic              id_gnt,
  output logic              id_rvalid,
  output logic [DATA_W-1:0] id_rdata,
  output logic              id_fault,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] BASE = L_INS[ADDR_W:0];

  state_e            state_q;
  logic              own_q;
  // nul_q: the pending return carries zero data (out of range)
  logic              nul_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] id_rdata_q;

  logic              idle;
  logic              in_ind;
  logic [ADDR_W:0]   id_sum;
  logic [ADDR_W:0]   ptr_sum;
  logic              id_oob;
  logic              ptr_oob;
  logic              if_oob;
  logic [DATA_W-1:0] ret;

  assign idle   = (state_q == S_IDLE) && !rst;
  assign in_ind = (state_q == S_IND) && !rst;
  assign ld_gnt = idle && ld_req;

  // One extra bit so a carry past the top of memory is visible
  assign id_sum  = BASE + {1'b0, id_addr};
  assign ptr_sum = BASE + {1'b0, mem_rdata[ADDR_W-1:0]};
  assign id_oob  = id_sum[ADDR_W];
  assign ptr_oob = ptr_sum[ADDR_W];
  assign if_oob  = {1'b0, if_addr} >= BASE;

  acc_rr_pick u_pick (
    .clk_i    (clk1),
    .rst_i    (rst),
    .en_i     (idle),
    .ovr_i    (ld_req),
    .req_if_i (if_req),
    .req_id_i (id_req),
    .gnt_if_o (if_gnt),
    .gnt_id_o (id_gnt)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      ld_gnt: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      if_gnt: begin
        if (!if_oob) begin
          mem_en   = 1'b1;
          mem_addr = if_addr;
        end
      end
      id_gnt: begin
        if (!id_oob) begin
          mem_en   = 1'b1;
          mem_addr = id_sum[ADDR_W-1:0];
        end
      end
      in_ind: begin
        if (!ptr_oob) begin
          mem_en   = 1'b1;
          mem_addr = ptr_sum[ADDR_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= REQ_IF;
      nul_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (if_gnt) begin
            state_q <= S_RD;
            own_q   <= REQ_IF;
            nul_q   <= if_oob;
          end else if (id_gnt) begin
            own_q   <= REQ_ID;
            nul_q   <= id_oob;
            // A bad base address faults before the pointer read
            state_q <= (id_ind && !id_oob) ? S_IND : S_RD;
          end
        end
        S_IND: begin
          state_q <= S_RD2;
          nul_q   <= ptr_oob;
        end
        S_RD:    state_q <= S_IDLE;
        S_RD2:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_rvalid = !rst && state_q == S_RD && own_q == REQ_IF;
  assign id_rvalid = !rst && (state_q == S_RD2 ||
                     (state_q == S_RD && own_q == REQ_ID));
  assign id_fault  = id_rvalid && nul_q;
  assign ret       = nul_q ? '0 : mem_rdata;

  always_ff @(posedge clk1) begin
    if (rst) begin
      if_rdata_q <= '0;
      id_rdata_q <= '0;
    end else begin
      if (if_rvalid)
        if_rdata_q <= ret;
      if (id_rvalid)
        id_rdata_q <= ret;
    end
  end

  assign if_rdata = if_rvalid ? ret : if_rdata_q;
  assign id_rdata = id_rvalid ? ret : id_rdata_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Directed + random bench for acc_mem_arbiter with a memory model
// and a transaction-level expectation model.
module tb_acc_mem_arbiter;

  localparam int LI = 401;
  localparam int MW = 1024;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        if_req;
  logic [9:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [15:0] if_rdata;
  logic        id_req;
  logic        id_ind;
  logic [9:0]  id_addr;
  logic        id_gnt;
  logic        id_rvalid;
  logic [15:0] id_rdata;
  logic        id_fault;
  logic        ld_req;
  logic [9:0]  ld_addr;
  logic [15:0] ld_wdata;
  logic        ld_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [MW];
  logic [15:0] mem_ref [MW];
  int          checks = 0;
  int          errors = 0;
  bit          fav_id;

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we)
        mem[mem_addr] <= mem_wdata;
      else
        mem_rdata <= mem[mem_addr];
    end
  end

  acc_mem_arbiter dut (
    .clk1      (clk1),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .id_req    (id_req),
    .id_ind    (id_ind),
    .id_addr   (id_addr),
    .id_gnt    (id_gnt),
    .id_rvalid (id_rvalid),
    .id_rdata  (id_rdata),
    .id_fault  (id_fault),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_gnt    (ld_gnt),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ld_write(input int a, input logic [15:0] d);
    ld_req = 1'b1;
    ld_addr = 10'(a);
    ld_wdata = d;
    #4;
    chk("ld_gnt", ld_gnt, 1);
    chk("ld_we", mem_we, 1);
    chk("ld_addr", mem_addr, a);
    chk("ld_data", mem_wdata, d);
    mem_ref[a] = d;
    @(posedge clk1); #1;
    ld_req = 1'b0;
  endtask

  task automatic if_read(input int a);
    int n;
    logic [15:0] ev;
    bit een;
    een = (a < LI);
    ev = een ? mem_ref[a] : 16'h0;
    if_req = 1'b1;
    if_addr = 10'(a);
    #4;
    n = 0;
    while (!if_gnt && n < 10) begin
      @(posedge clk1); #5;
      n++;
    end
    chk("if_gnt", if_gnt, 1);
    chk("if_en", mem_en, een);
    if (een) chk("if_addr", mem_addr, a);
    fav_id = 1'b1;
    @(posedge clk1); #1;
    if_req = 1'b0;
    #4;
    chk("if_rvalid", if_rvalid, 1);
    chk("if_rdata", if_rdata, ev);
    @(posedge clk1); #5;
    chk("if_pulse", if_rvalid, 0);
    chk("if_hold", if_rdata, ev);
    @(posedge clk1); #1;
  endtask

  task automatic id_read(input int rel, input bit ind);
    int n, eff, p, e2, el;
    logic [15:0] ev;
    bit ef, een, pok;
    eff = LI + rel;
    pok = 1'b0;
    e2 = 0;
    if (eff >= MW) begin
      ev = 0; ef = 1; el = 1; een = 0;
    end else if (!ind) begin
      ev = mem_ref[eff]; ef = 0; el = 1; een = 1;
    end else begin
      p = int'(mem_ref[eff] & 16'h03ff);
      e2 = LI + p;
      pok = (e2 < MW);
      ev = pok ? mem_ref[e2] : 16'h0;
      ef = !pok; el = 2; een = 1;
    end
    id_req = 1'b1;
    id_ind = ind;
    id_addr = 10'(rel);
    #4;
    n = 0;
    while (!id_gnt && n < 10) begin
      @(posedge clk1); #5;
      n++;
    end
    chk("id_gnt", id_gnt, 1);
    chk("id_en", mem_en, een);
    if (een) chk("id_addr", mem_addr, eff);
    fav_id = 1'b0;
    @(posedge clk1); #1;
    id_req = 1'b0;
    #4;
    if (el == 2) begin
      chk("ind_en", mem_en, pok);
      if (pok) chk("ind_addr", mem_addr, e2);
    end
    n = 1;
    while (!id_rvalid && n < 6) begin
      @(posedge clk1); #5;
      n++;
    end
    chk("id_lat", n, el);
    chk("id_rdata", id_rdata, ev);
    chk("id_fault", id_fault, ef);
    @(posedge clk1); #5;
    chk("id_pulse", id_rvalid | id_fault, 0);
    chk("id_hold", id_rdata, ev);
    @(posedge clk1); #1;
  endtask

  initial begin
    bit last_id;
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    id_req = 0; id_ind = 0; id_addr = 0;
    ld_req = 0; ld_addr = 0; ld_wdata = 0;
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    fav_id = 1'b1;
    #4;
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_id_gnt", id_gnt, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_rv", if_rvalid, 0);
    chk("rst_id_rv", id_rvalid, 0);
    chk("rst_fault", id_fault, 0);
    chk("rst_if_rd", if_rdata, 0);
    chk("rst_id_rd", id_rdata, 0);
    @(posedge clk1); #1;

    // all three request together: loader, then ID, then IF
    ld_req = 1; ld_addr = 10'd406; ld_wdata = 16'h1234;
    if_req = 1; if_addr = 10'd10;
    id_req = 1; id_ind = 0; id_addr = 10'd5;
    #4;
    chk("pr_ld_gnt", ld_gnt, 1);
    chk("pr_id_gnt0", id_gnt, 0);
    chk("pr_if_gnt0", if_gnt, 0);
    chk("pr_we", mem_we, 1);
    mem_ref[406] = 16'h1234;
    @(posedge clk1); #1;
    ld_req = 0;
    #4;
    chk("pr_id_gnt", id_gnt, 1);
    chk("pr_if_wait", if_gnt, 0);
    chk("pr_rd_addr", mem_addr, 406);
    @(posedge clk1); #1;
    id_req = 0;
    #4;
    chk("pr_id_rv", id_rvalid, 1);
    chk("pr_id_rd", id_rdata, 16'h1234);
    chk("pr_if_busy", if_gnt, 0);
    @(posedge clk1); #5;
    chk("pr_if_gnt", if_gnt, 1);
    @(posedge clk1); #1;
    if_req = 0;
    #4;
    chk("pr_if_rv", if_rvalid, 1);
    @(posedge clk1); #1;
    fav_id = 1'b1;

    ld_req = 1'b1;
    for (int i = 0; i < MW; i++) begin
      ld_addr = 10'(i);
      ld_wdata = 16'($urandom);
      mem_ref[i] = ld_wdata;
      @(posedge clk1); #1;
    end
    ld_req = 1'b0;

    ld_write(406, 16'h1234);
    ld_write(403, 16'd7);
    ld_write(408, 16'hBEEF);
    ld_write(421, 16'd700);

    id_read(5, 0);
    id_read(2, 1);
    id_read(623, 0);
    id_read(622, 0);
    id_read(20, 1);
    if_read(400);
    if_read(401);

    // both requesters held: strict alternation, one read per 2 cycles
    if_req = 1; if_addr = 10'd100;
    id_req = 1; id_ind = 0; id_addr = 10'd5;
    last_id = 1'b0;
    #4;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        chk("rr_id_gnt", id_gnt, fav_id);
        chk("rr_if_gnt", if_gnt, !fav_id);
        last_id = fav_id;
        fav_id = !fav_id;
      end else begin
        chk("rr_gap", id_gnt | if_gnt, 0);
        if (last_id) begin
          chk("rr_id_rv", id_rvalid, 1);
          chk("rr_id_rd", id_rdata, mem_ref[406]);
        end else begin
          chk("rr_if_rv", if_rvalid, 1);
          chk("rr_if_rd", if_rdata, mem_ref[100]);
        end
      end
      @(posedge clk1); #5;
    end
    if_req = 0; id_req = 0;
    @(posedge clk1); #1;

    // reset while the pointer read is outstanding
    id_req = 1; id_ind = 1; id_addr = 10'd2;
    #4;
    chk("ri_gnt", id_gnt, 1);
    @(posedge clk1); #1;
    id_req = 0;
    rst = 1'b1;
    #4;
    chk("ri_rv_rst", id_rvalid, 0);
    @(posedge clk1); #1;
    rst = 1'b0;
    fav_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("ri_no_rv", id_rvalid, 0);
      chk("ri_no_en", mem_en, 0);
      @(posedge clk1); #1;
    end
    id_read(2, 1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(3))
        0: ld_write(int'($urandom_range(1023)), 16'($urandom));
        1: if_read(int'($urandom_range(1023)));
        2: id_read(int'($urandom_range(1023)), 0);
        default: id_read(int'($urandom_range(700)), 1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_mem_arbiter.md
ACC_MEM_ARBITER -- requirements
Module: acc_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 10, unified memory address width (1024 words).
REQ-003 SHALL have parameter L_INS, default 401, instruction-region size; data region is L_INS..2**ADDR_W-1.
REQ-004 SHALL have ports: clk1 in 1, sole clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have IF port: if_req in 1; if_addr in ADDR_W, instruction address; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-006 SHALL have ID port: id_req in 1; id_ind in 1, indirect access; id_addr in ADDR_W, data-region-relative; id_gnt out 1; id_rvalid out 1; id_rdata out DATA_W; id_fault out 1.
REQ-007 SHALL have loader port: ld_req in 1; ld_addr in ADDR_W, absolute; ld_wdata in DATA_W; ld_gnt out 1.
REQ-008 SHALL have memory port: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid the cycle after mem_en with mem_we=0.

Function
REQ-009 SHALL use FSM states IDLE, RD (direct read outstanding), IND (pointer read outstanding), RD2 (indirect second read outstanding).
REQ-010 SHALL arbitrate only in IDLE; gnt outputs and mem_en are combinational from IDLE and requests, at most one gnt per cycle.
REQ-011 SHALL give ld_req absolute priority; IF and ID round-robin, pointer moving to the other requester after each grant; pointer favours ID after reset.
REQ-012 Loader grant SHALL drive mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata in the grant cycle; FSM stays IDLE.
REQ-013 IF grant SHALL issue a read at if_addr and go to RD; next cycle if_rvalid=1, if_rdata=mem_rdata, return to IDLE.
REQ-014 ID direct grant SHALL read L_INS+id_addr, go to RD; next cycle id_rvalid=1, id_rdata=mem_rdata.
REQ-015 ID indirect grant SHALL read L_INS+id_addr, go to IND; in IND issue read at L_INS+mem_rdata[ADDR_W-1:0] and go to RD2; in RD2 assert id_rvalid with mem_rdata (latency 2 cycles after grant).
REQ-016 Address math SHALL be ADDR_W+1 bits; a data-relative address >= 2**ADDR_W-L_INS SHALL not access memory and SHALL return id_rvalid=1, id_fault=1, id_rdata=0 one cycle after detection (grant cycle or IND cycle).
REQ-017 if_addr >= L_INS SHALL still be granted but return if_rdata=0 without mem_en.
REQ-018 rvalid/fault outputs SHALL be single-cycle pulses; rdata SHALL hold last value until next rvalid.
REQ-019 Requesters SHALL hold req and address until gnt; requests arriving outside IDLE SHALL wait.
REQ-020 mem_en=0, mem_we=0 whenever no access is issued.

Reset
REQ-021 rst SHALL force IDLE, all gnt/rvalid/fault/mem_en/mem_we to 0, rdata registers to 0, RR pointer to ID.
REQ-022 rst during RD/IND/RD2 SHALL drop the access; no rvalid SHALL follow.

Structure
REQ-023 SHALL place state enum, DATA_W/ADDR_W/L_INS defaults and requester-ID constants in shared package acc_pkg.
REQ-024 SHALL use one sub-module acc_rr_pick (two-requester round-robin pointer with priority override).

Verification
REQ-025 ld_req, if_req, id_req same cycle after reset -> ld_gnt=1, mem_we=1; next cycle id_gnt; IF served after ID.
REQ-026 id_req direct, id_addr=5, mem[406]=0x1234 -> mem_addr=406, id_rvalid next cycle, id_rdata=0x1234.
REQ-027 id_req indirect, id_addr=2, mem[403]=7, mem[408]=0xBEEF -> reads 403 then 408, id_rvalid 2 cycles after grant, id_rdata=0xBEEF.
REQ-028 id_addr=623 direct -> no mem_en, id_fault=1, id_rdata=0; indirect with pointer 700 -> fault after IND.
REQ-029 if_req and id_req held continuously -> grants alternate ID,IF,ID,IF, one read per 2 cycles.
REQ-030 rst asserted in IND -> IDLE next cycle, no id_rvalid, subsequent request served normally.
